// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter for a block-transfer memory port.
// Each grant runs one command pulse, a ready-low/ready-high handshake and a BURST-beat data phase.
module mem_arbiter #(
  parameter int unsigned WIDTH_a = 16,
  parameter int unsigned WIDTH_d = 8,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               c0_rd,
  input  logic               c0_wr,
  input  logic [WIDTH_a-1:0] c0_addr,
  input  logic [WIDTH_d-1:0] c0_wdata,
  output logic [WIDTH_d-1:0] c0_rdata,
  output logic               c0_valid,
  output logic               c0_done,
  input  logic               c1_rd,
  input  logic               c1_wr,
  input  logic [WIDTH_a-1:0] c1_addr,
  input  logic [WIDTH_d-1:0] c1_wdata,
  output logic [WIDTH_d-1:0] c1_rdata,
  output logic               c1_valid,
  output logic               c1_done,
  output logic [1:0]         grant,
  output logic [WIDTH_a-1:0] mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [WIDTH_d-1:0] mem_wdata,
  input  logic [WIDTH_d-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               timeout_err
);
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, XFER, DONE} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_grant;
  logic               r_last;
  logic [WIDTH_a-1:0] r_addr;
  logic               r_is_rd;
  logic [BW-1:0]      r_beat;
  logic [TW-1:0]      r_tcnt;
  logic [WIDTH_d-1:0] r_rdata0, r_rdata1;
  logic [1:0]         r_rvalid;

  logic w_req0, w_req1, w_pick1, w_tmo, w_xfer_wr;

  always_comb begin
    w_req0    = c0_rd | c0_wr;
    w_req1    = c1_rd | c1_wr;
    // r_last=1 means c1 owned the port last, so c0 wins a tie.
    w_pick1   = w_req1 & (~w_req0 | ~r_last);
    w_tmo     = ((r_state == WAIT_LO) || (r_state == WAIT_HI)) &&
                (r_tcnt == TW'(TIMEOUT - 1));
    w_xfer_wr = (r_state == XFER) && !r_is_rd;
    w_next    = r_state;
    case (r_state)
      IDLE:    if (w_req0 || w_req1) w_next = ISSUE;
      ISSUE:   if (mem_ready) w_next = WAIT_LO;
      WAIT_LO: if (w_tmo) w_next = DONE; else if (!mem_ready) w_next = WAIT_HI;
      WAIT_HI: if (w_tmo) w_next = DONE; else if (mem_ready) w_next = XFER;
      XFER:    if (r_beat == BW'(BURST - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    grant       = r_grant;
    mem_addr    = r_addr;
    mem_rd      = (r_state == ISSUE) && mem_ready && r_is_rd;
    mem_wr      = (r_state == ISSUE) && mem_ready && !r_is_rd;
    mem_wdata   = w_xfer_wr ? (r_grant[1] ? c1_wdata : c0_wdata) : '0;
    c0_rdata    = r_rdata0;
    c1_rdata    = r_rdata1;
    c0_valid    = r_rvalid[0] | (w_xfer_wr & r_grant[0]);
    c1_valid    = r_rvalid[1] | (w_xfer_wr & r_grant[1]);
    c0_done     = (r_state == DONE) && r_grant[0];
    c1_done     = (r_state == DONE) && r_grant[1];
    timeout_err = w_tmo;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_is_rd  <= 1'b0;
      r_beat   <= '0;
      r_tcnt   <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= '0;
      case (r_state)
        IDLE: if (w_req0 || w_req1) begin
          r_grant <= {w_pick1, ~w_pick1};
          r_addr  <= (w_pick1 ? c1_addr : c0_addr) & ~WIDTH_a'(3);
          r_is_rd <= w_pick1 ? c1_rd : c0_rd;
        end
        ISSUE:   if (mem_ready) r_tcnt <= '0;
        WAIT_LO: r_tcnt <= r_tcnt + TW'(1);
        WAIT_HI: begin
          r_tcnt <= r_tcnt + TW'(1);
          r_beat <= '0;
        end
        XFER: begin
          r_beat <= (r_beat == BW'(BURST - 1)) ? '0 : r_beat + BW'(1);
          if (r_is_rd) begin
            r_rvalid <= r_grant;
            if (r_grant[0]) r_rdata0 <= mem_rdata;
            if (r_grant[1]) r_rdata1 <= mem_rdata;
          end
        end
        DONE: begin
          r_last  <= r_grant[1];
          r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a table of transactions served by a small memory responder,
// with read bytes tracked through a scoreboard queue and write bytes through an expected queue.
module tb_mem_arbiter;
  localparam int AW = 16, DW = 8, NB = 4, TMO = 255;

  logic          clock, reset_n;
  logic          c0_rd, c0_wr, c1_rd, c1_wr;
  logic [AW-1:0] c0_addr, c1_addr, mem_addr;
  logic [DW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata, mem_wdata, mem_rdata;
  logic          c0_valid, c1_valid, c0_done, c1_done;
  logic [1:0]    grant;
  logic          mem_rd, mem_wr, mem_ready, timeout_err;

  mem_arbiter #(.WIDTH_a(AW), .WIDTH_d(DW), .BURST(NB), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .c0_valid(c0_valid), .c0_done(c0_done),
    .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_rdata(c1_rdata), .c1_valid(c1_valid), .c1_done(c1_done),
    .grant(grant), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          r0, w0, r1, w1;
    logic [15:0] a0, a1;
    int          hold;      // cycles mem_ready is low from the request on
    int          lat;       // cycles mem_ready is low after the command
    logic [31:0] data;      // winner's bytes, beat k in data[8k+:8]
    bit          drop;      // withdraw requests once granted
    logic [1:0]  exp_grant;
    bit          exp_rd;
    logic [15:0] exp_addr;
  } vec_t;

  int          n_cmp = 0, n_bad = 0;
  logic [8:0]  rq[$];
  logic [7:0]  wq[$];
  logic [7:0]  exp_last[2];
  int          mm_p;
  bit          mm_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r0, bit w0, bit r1, bit w1, logic [15:0] a0, logic [15:0] a1,
                              int hold, int lat, logic [31:0] data, bit drop,
                              logic [1:0] g, bit rd, logic [15:0] ea);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.a0 = a0; v.a1 = a1;
    v.hold = hold; v.lat = lat; v.data = data; v.drop = drop;
    v.exp_grant = g; v.exp_rd = rd; v.exp_addr = ea;
    return v;
  endfunction

  task automatic drive_wdata(input vec_t v, input int wi);
    logic [7:0] b;
    b = (wi < NB) ? v.data[8*wi +: 8] : 8'h00;
    c0_wdata = v.exp_grant[1] ? 8'hE7 : b;
    c1_wdata = v.exp_grant[1] ? b : 8'hE7;
  endtask

  // Runs one transaction from the IDLE cycle; call just after a rising edge.
  // rst_beat >= 0 asserts reset during that XFER beat and abandons the transaction.
  task automatic run_txn(input vec_t v, input int rst_beat);
    int         hold_left = v.hold, ncmd = 0, nbeat = 0, ndone = 0, nother = 0, nviol = 0;
    int         t_cmd = -1, t_tmo = -1, t_done = -1, wi = 0;
    logic [1:0] cmd_type = 2'b00;
    logic [15:0] cmd_addr = '0;
    logic [8:0] e;
    bit         done = 0, abort = 0, win1 = v.exp_grant[1];
    bit         tmo_case = (v.lat >= 1000);
    c0_rd = v.r0; c0_wr = v.w0; c1_rd = v.r1; c1_wr = v.w1;
    c0_addr = v.a0; c1_addr = v.a1;
    drive_wdata(v, 0);
    mm_p = 0; mm_pend = 0; mem_rdata = '0;
    mem_ready = (hold_left > 0) ? 1'b0 : 1'b1;
    if (!v.exp_rd && !tmo_case)
      for (int k = 0; k < NB; k++) wq.push_back(v.data[8*k +: 8]);
    for (int i = 0; i < 2000 && !done && !abort; i++) begin
      @(negedge clock);
      if (i == 0) check("grant_idle", grant, 2'b00);
      if (i == 1) check("grant", grant, v.exp_grant);
      if (mem_rd || mem_wr) begin
        ncmd++;
        if (ncmd == 1) begin
          cmd_type = {mem_rd, mem_wr}; cmd_addr = mem_addr; t_cmd = i; mm_pend = 1;
        end
      end
      if (mem_rd && mem_wr) nviol++;
      if (!v.exp_rd && mm_p >= v.lat + 2 && mm_p <= v.lat + 1 + NB) begin
        if (wq.size() == 0) nviol++;
        else check("mem_wdata", mem_wdata, wq.pop_front());
        nbeat++;
      end else if (mem_wdata !== '0) nviol++;
      if (v.exp_rd && (c0_valid || c1_valid)) begin
        if (rq.size() == 0) nviol++;
        else begin
          e = rq.pop_front();
          check("rd_beat", {c1_valid, c0_valid, (c1_valid ? c1_rdata : c0_rdata)},
                {e[8], ~e[8], e[7:0]});
          exp_last[e[8]] = e[7:0];
          nbeat++;
        end
      end
      if (!v.exp_rd && (win1 ? c1_valid : c0_valid)) wi++;
      if (win1 ? c0_valid : c1_valid) nother++;
      if (win1 ? c0_done : c1_done) nother++;
      if (timeout_err) t_tmo = i;
      if (win1 ? c1_done : c0_done) begin ndone++; done = 1; t_done = i; end
      @(posedge clock); #1;
      if (v.drop && i >= 1) begin c0_rd = 0; c0_wr = 0; c1_rd = 0; c1_wr = 0; end
      if (hold_left > 0) hold_left--;
      if (mm_pend) begin mm_p = 1; mm_pend = 0; end
      else if (mm_p > 0) mm_p++;
      mem_ready = (hold_left > 0 || (mm_p >= 1 && mm_p <= v.lat)) ? 1'b0 : 1'b1;
      mem_rdata = '0;
      if (v.exp_rd && mm_p >= v.lat + 2 && mm_p <= v.lat + 1 + NB) begin
        mem_rdata = v.data[8*(mm_p - v.lat - 2) +: 8];
        rq.push_back({win1, mem_rdata});
      end
      drive_wdata(v, wi);
      if (rst_beat >= 0 && mm_p == v.lat + 2 + rst_beat) begin
        check("pre_reset", {grant, mem_addr, c0_valid}, {v.exp_grant, v.exp_addr, 1'b1});
        #2 reset_n = 1'b0;
        #1 check("async_reset", {grant, mem_addr, mem_rd, mem_wr, mem_wdata, c0_rdata, c1_rdata,
                                 c0_valid, c1_valid, c0_done, c1_done, timeout_err}, 64'h0);
        abort = 1;
      end
    end
    c0_rd = 0; c0_wr = 0; c1_rd = 0; c1_wr = 0;
    if (abort) return;
    mem_ready = 1'b1; mem_rdata = '0;
    check("cmd_count", ncmd, 1);
    check("cmd_type", cmd_type, v.exp_rd ? 2'b10 : 2'b01);
    check("cmd_addr", cmd_addr, v.exp_addr);
    check("cmd_cycle", t_cmd, (v.hold > 1) ? v.hold : 1);
    check("done_count", ndone, 1);
    if (tmo_case) begin
      check("timeout_cycle", t_tmo, t_cmd + TMO);
      check("done_cycle", t_done, t_cmd + TMO + 1);
      check("beats", nbeat, 0);
    end else begin
      check("timeout_none", t_tmo, -1);
      check("done_cycle", t_done, t_cmd + v.lat + 2 + NB);
      check("beats", nbeat, NB);
    end
    if (!v.exp_rd && !tmo_case) check("wr_advance", wi, NB);
    check("other_client", nother, 0);
    check("protocol", nviol, 0);
    check("queues_empty", rq.size() + wq.size(), 0);
    check("rdata_hold", {c1_rdata, c0_rdata}, {exp_last[1], exp_last[0]});
  endtask

  vec_t tbl[11];
  vec_t v_rst, v_after;

  initial begin
    tbl[0]  = mk(1,0,0,1, 16'h1234, 16'h5677, 0, 3, 32'h87654321, 0, 2'b01, 1, 16'h1234);
    tbl[1]  = mk(0,0,0,1, 16'h1234, 16'h5677, 0, 2, 32'hDDCCBBAA, 0, 2'b10, 0, 16'h5674);
    tbl[2]  = mk(1,0,0,0, 16'h00A3, 16'h0000, 0, 4, 32'h44332211, 0, 2'b01, 1, 16'h00A0);
    tbl[3]  = mk(0,1,1,0, 16'h2001, 16'h8003, 0, 1, 32'h0D0C0B0A, 0, 2'b10, 1, 16'h8000);
    tbl[4]  = mk(0,1,1,0, 16'h2001, 16'h8003, 0, 1, 32'h1A2B3C4D, 0, 2'b01, 0, 16'h2000);
    tbl[5]  = mk(0,1,1,0, 16'h2001, 16'h8003, 0, 2, 32'h55667788, 0, 2'b10, 1, 16'h8000);
    tbl[6]  = mk(1,1,1,0, 16'hFFFF, 16'h8003, 4, 2, 32'h9ABCDEF0, 0, 2'b01, 1, 16'hFFFC);
    tbl[7]  = mk(0,0,1,1, 16'h0000, 16'h0ABE, 0, 5, 32'h13579BDF, 1, 2'b10, 1, 16'h0ABC);
    tbl[8]  = mk(1,0,0,0, 16'h4447, 16'h0000, 0, 100000, 32'h0, 0, 2'b01, 1, 16'h4444);
    tbl[9]  = mk(0,0,0,1, 16'h0000, 16'h7772, 0, 1, 32'hF00DCAFE, 0, 2'b10, 0, 16'h7770);
    tbl[10] = mk(0,1,0,1, 16'h0004, 16'h0008, 0, 1, 32'h01020304, 0, 2'b01, 0, 16'h0004);
    v_rst   = mk(1,0,0,0, 16'h3C41, 16'h0000, 0, 2, 32'hA1B2C3D4, 0, 2'b01, 1, 16'h3C40);
    v_after = mk(0,0,1,0, 16'h0000, 16'h6006, 0, 3, 32'h77665544, 0, 2'b10, 1, 16'h6004);

    reset_n = 1'b0; mem_ready = 1'b1; mem_rdata = '0;
    c0_rd = 0; c0_wr = 0; c1_rd = 0; c1_wr = 0;
    c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
    exp_last[0] = '0; exp_last[1] = '0;
    repeat (3) @(posedge clock);
    #1 check("reset_state", {grant, mem_addr, mem_rd, mem_wr, mem_wdata, c0_rdata, c1_rdata,
                             c0_valid, c1_valid, c0_done, c1_done, timeout_err}, 64'h0);
    reset_n = 1'b1;
    for (int r = 0; r < 11; r++) run_txn(tbl[r], -1);

    run_txn(v_rst, 2);
    rq.delete(); wq.delete();
    exp_last[0] = '0; exp_last[1] = '0;
    mm_p = 0; mm_pend = 0; mem_ready = 1'b1; mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    run_txn(v_after, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched",
             n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH_a, default 16, address bus width.
REQ-002 Parameter WIDTH_d, default 8, data bus width.
REQ-003 Parameter BURST, default 4, beats per block transfer.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles spent waiting on mem_ready.
REQ-005 clock  input  1  clock; all state SHALL change on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 cN_rd  input  1  client N (N=0,1) block-read request, level, held until cN_done.
REQ-008 cN_wr  input  1  client N block-write request, level, held until cN_done.
REQ-009 cN_addr  input  WIDTH_a  client N block address.
REQ-010 cN_wdata  input  WIDTH_d  client N write byte for the current beat.
REQ-011 cN_rdata  output  WIDTH_d  read byte to client N, registered.
REQ-012 cN_valid  output  1  client N beat strobe: rdata valid (read) or wdata consumed (write).
REQ-013 cN_done  output  1  one-cycle pulse at the end of client N's transaction.
REQ-014 grant  output  2  one-hot owner of the memory port; 2'b00 when idle.
REQ-015 mem_addr  output  WIDTH_a  block address to main memory, low 2 bits zero.
REQ-016 mem_rd / mem_wr  output  1 each  one-cycle command pulses to main memory.
REQ-017 mem_wdata  output  WIDTH_d  write byte to main memory.
REQ-018 mem_rdata  input  WIDTH_d  read byte from main memory.
REQ-019 mem_ready  input  1  high = memory idle or data phase; low = memory busy.
REQ-020 timeout_err  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-021 States SHALL be IDLE, ISSUE, WAIT_LO, WAIT_HI, XFER, DONE.
REQ-022 IDLE: with no request, grant=00; with any request, move to ISSUE next cycle.
REQ-023 Arbitration in IDLE: single requester wins; if both request, the client not granted last wins (round-robin); last_grant resets to 1, so c0 wins the first contention.
REQ-024 On leaving IDLE: latch winner's address as {cN_addr[WIDTH_a-1:2],2'b00} into mem_addr, latch direction (cN_rd has priority over cN_wr from the same client), set grant.
REQ-025 ISSUE: if mem_ready=1, assert mem_rd or mem_wr for exactly one cycle and go to WAIT_LO; else hold ISSUE with both commands low.
REQ-026 WAIT_LO: wait for mem_ready=0, then go to WAIT_HI.
REQ-027 WAIT_HI: on mem_ready=1, go to XFER with beat counter=0.
REQ-028 XFER lasts exactly BURST cycles, beat 0 = lowest byte address; counter wraps to 0 on exit.
REQ-029 XFER read: each cycle register mem_rdata into cN_rdata of the granted client and assert its cN_valid for that beat (one cycle later than the mem_rdata sample).
REQ-030 XFER write: mem_wdata SHALL combinationally equal granted cN_wdata; cN_valid high each beat, so the client advances one byte per cycle.
REQ-031 DONE: pulse granted cN_done for one cycle, record last_grant, clear grant, return to IDLE; a new request is arbitrated no earlier than the following cycle.
REQ-032 Timeout counter clears on entry to WAIT_LO and increments each cycle in WAIT_LO/WAIT_HI; on reaching TIMEOUT, pulse timeout_err and enter DONE (cN_done still pulses).
REQ-033 Requests withdrawn after grant are ignored; the transaction runs to completion.
REQ-034 Non-granted client: cN_valid=0, cN_done=0, cN_rdata holds its last value.
REQ-035 mem_wdata SHALL be 0 outside XFER-write; mem_rd and mem_wr SHALL never be high together.

Reset
REQ-036 reset_n low SHALL immediately force state=IDLE, grant=00, last_grant=1, all counters 0, and mem_addr, mem_rd, mem_wr, mem_wdata, cN_rdata, cN_valid, cN_done, timeout_err all 0, including mid-transaction.
REQ-037 After reset release, the first request is accepted on the first rising edge with reset_n high.

Verification
REQ-038 c0_rd, addr 0x00A3, mem_ready toggles low 4 cycles, bytes 11,22,33,44 -> mem_addr=0x00A0, one mem_rd pulse, c0_rdata 11,22,33,44 with c0_valid, one c0_done.
REQ-039 c0_rd and c1_wr asserted together after reset -> c0 served first, then c1; mem_wr pulse with mem_addr=c1 block address; c1 bytes AA,BB,CC,DD appear on mem_wdata.
REQ-040 Both clients requesting continuously -> grants alternate 01,10,01,10; no starvation.
REQ-041 mem_ready held low after command -> timeout_err and cN_done pulse after TIMEOUT cycles; next request served normally.
REQ-042 reset_n driven low during XFER beat 2 -> all outputs 0 asynchronously; after release, new c1_rd completes normally.
REQ-043 mem_ready low while in ISSUE for 3 cycles -> no command issued until mem_ready=1, then exactly one pulse.
